// File: rtl/nes_irq_ctrl.sv
// NES interrupt controller: 8 prioritised level/edge sources behind an Avalon-MM
// register window, with a single in-service slot acknowledged by a VECTOR read.
module nes_irq_ctrl #(
   parameter int NUM_SRC = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          address,
   input  logic                chipselect,
   input  logic                read_n,
   input  logic                write_n,
   input  logic [15:0]         writedata,
   input  logic [NUM_SRC-1:0]  irq_in,
   output logic [15:0]         readdata,
   output logic                cpu_irq
);

   localparam logic [2:0] A_PENDING  = 3'd0;
   localparam logic [2:0] A_ENABLE   = 3'd1;
   localparam logic [2:0] A_MODE     = 3'd2;
   localparam logic [2:0] A_VECTOR   = 3'd3;
   localparam logic [2:0] A_INSERV   = 3'd4;
   localparam logic [2:0] A_RAW      = 3'd5;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   function automatic logic [2:0] f_lowest(input logic [NUM_SRC-1:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [NUM_SRC-1:0] f_onehot(input logic [2:0] idx);
      logic [NUM_SRC-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [15:0] f_zext(input logic [NUM_SRC-1:0] v);
      return {{(16 - NUM_SRC){1'b0}}, v};
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NUM_SRC-1:0] r_irq_in_d;
   logic [NUM_SRC-1:0] r_edge_pend;
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_mode;
   logic [2:0]         r_isr_idx;
   logic [15:0]        r_readdata;
   logic               r_cpu_irq;

   logic               w_rd;
   logic               w_wr;
   logic               w_rd_only;
   logic [NUM_SRC-1:0] w_pending;
   logic [NUM_SRC-1:0] w_request;
   logic               w_any;
   logic [2:0]         w_winner;
   logic               w_ack;
   logic               w_eoi;
   logic [NUM_SRC-1:0] w_wdata;
   logic [NUM_SRC-1:0] w_mode_nxt;
   logic [NUM_SRC-1:0] w_rise;
   logic [NUM_SRC-1:0] w_clr_w1c;
   logic [NUM_SRC-1:0] w_clr_mode;
   logic [NUM_SRC-1:0] w_clr_ack;
   logic [NUM_SRC-1:0] w_edge_nxt;
   logic [15:0]        w_rd_data;
   logic               w_unused;

   assign w_rd      = chipselect & ~read_n;
   assign w_wr      = chipselect & ~write_n;
   // A simultaneous write wins: the read's side effects (acknowledge) are suppressed.
   assign w_rd_only = w_rd & ~w_wr;
   assign w_wdata   = writedata[NUM_SRC-1:0];
   assign w_unused  = ^writedata[15:NUM_SRC];

   assign w_pending = (r_edge_pend & r_mode) | (r_irq_in_d & ~r_mode);
   assign w_request = w_pending & r_enable;
   assign w_any     = |w_request;
   assign w_winner  = f_lowest(w_request);

   assign w_ack = w_rd_only && (address == A_VECTOR) && (r_state == ST_IDLE) && w_any;
   assign w_eoi = w_wr && (address == A_INSERV) && (r_state == ST_ACTIVE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_ack) begin
               w_state_nxt = ST_ACTIVE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (w_eoi) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_ACTIVE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A new rising edge is OR-ed in after all clears, so set always beats clear.
   always_comb begin
      w_mode_nxt = r_mode;
      w_clr_w1c  = '0;
      w_clr_ack  = '0;
      if (w_wr && (address == A_MODE)) begin
         w_mode_nxt = w_wdata;
      end else begin
         w_mode_nxt = r_mode;
      end
      if (w_wr && (address == A_PENDING)) begin
         w_clr_w1c = w_wdata & r_mode;
      end else begin
         w_clr_w1c = '0;
      end
      if (w_ack) begin
         w_clr_ack = f_onehot(w_winner) & r_mode;
      end else begin
         w_clr_ack = '0;
      end
   end

   assign w_rise     = irq_in & ~r_irq_in_d;
   assign w_clr_mode = r_mode & ~w_mode_nxt;
   assign w_edge_nxt = (r_edge_pend & ~(w_clr_w1c | w_clr_mode | w_clr_ack))
                     | (w_rise & w_mode_nxt);

   always_comb begin
      w_rd_data = 16'h0000;
      case (address)
         A_PENDING: w_rd_data = f_zext(w_pending);
         A_ENABLE:  w_rd_data = f_zext(r_enable);
         A_MODE:    w_rd_data = f_zext(r_mode);
         A_VECTOR: begin
            if (w_ack) begin
               w_rd_data = {1'b1, 12'h000, w_winner};
            end else begin
               w_rd_data = 16'h0000;
            end
         end
         A_INSERV:  w_rd_data = {(r_state == ST_ACTIVE), 12'h000, r_isr_idx};
         A_RAW:     w_rd_data = f_zext(r_irq_in_d);
         default:   w_rd_data = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // cpu_irq looks at the next state so an acknowledge drops it and an EOI
   // re-raises it on the very next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_in_d  <= '0;
         r_edge_pend <= '0;
         r_enable    <= '0;
         r_mode      <= '0;
         r_isr_idx   <= 3'd0;
         r_readdata  <= 16'h0000;
         r_cpu_irq   <= 1'b0;
      end else begin
         r_irq_in_d  <= irq_in;
         r_edge_pend <= w_edge_nxt;
         r_mode      <= w_mode_nxt;
         r_cpu_irq   <= (w_state_nxt == ST_IDLE) && w_any;
         if (w_wr && (address == A_ENABLE)) begin
            r_enable <= w_wdata;
         end else begin
            r_enable <= r_enable;
         end
         if (w_ack) begin
            r_isr_idx <= w_winner;
         end else begin
            r_isr_idx <= r_isr_idx;
         end
         if (w_rd) begin
            r_readdata <= w_wr ? 16'h0000 : w_rd_data;
         end else begin
            r_readdata <= r_readdata;
         end
      end
   end

   assign readdata = r_readdata;
   assign cpu_irq  = r_cpu_irq;

endmodule

// File: tb/tb_nes_irq_ctrl.sv
// Directed bench for nes_irq_ctrl: stimulus pushes expected values into queues,
// an independent monitor pops and compares when the DUT presents read data or a probe.
module tb_nes_irq_ctrl;

   localparam logic [2:0] A_PENDING = 3'd0;
   localparam logic [2:0] A_ENABLE  = 3'd1;
   localparam logic [2:0] A_MODE    = 3'd2;
   localparam logic [2:0] A_VECTOR  = 3'd3;
   localparam logic [2:0] A_INSERV  = 3'd4;
   localparam logic [2:0] A_RAW     = 3'd5;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [15:0] writedata;
   logic [7:0]  irq_in;
   logic [15:0] readdata;
   logic        cpu_irq;

   typedef struct {
      string       name;
      bit          on_irq;
      logic [15:0] exp;
   } exp_t;

   exp_t rspq[$];
   exp_t prbq[$];
   exp_t cur_r;
   exp_t cur_p;
   bit   rd_vld = 1'b0;
   int   n_vec  = 0;
   int   n_err  = 0;

   nes_irq_ctrl #(.NUM_SRC(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .irq_in     (irq_in),
      .readdata   (readdata),
      .cpu_irq    (cpu_irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_vld <= chipselect && !read_n;

   initial begin
      forever begin
         @(negedge clk);
         if (rd_vld) begin
            n_vec++;
            if (rspq.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_read: readdata=%h, no response was expected", readdata);
            end else begin
               cur_r = rspq.pop_front();
               if (readdata !== cur_r.exp) begin
                  n_err++;
                  $display("FAIL %s: readdata=%h expected %h", cur_r.name, readdata, cur_r.exp);
               end
            end
         end
         while (prbq.size() > 0) begin
            cur_p = prbq.pop_front();
            n_vec++;
            if (cur_p.on_irq) begin
               if (cpu_irq !== cur_p.exp[0]) begin
                  n_err++;
                  $display("FAIL %s: cpu_irq=%b expected %b", cur_p.name, cpu_irq, cur_p.exp[0]);
               end
            end else if (readdata !== cur_p.exp) begin
               n_err++;
               $display("FAIL %s: readdata=%h expected %h", cur_p.name, readdata, cur_p.exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_rd(input logic [2:0] a, input logic [15:0] e, input string nm);
      address    = a;
      chipselect = 1'b1;
      read_n     = 1'b0;
      rspq.push_back('{name: nm, on_irq: 1'b0, exp: e});
      tick();
      chipselect = 1'b0;
      read_n     = 1'b1;
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_rw(input logic [2:0] a, input logic [15:0] d, input logic [15:0] e,
                         input string nm);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      read_n     = 1'b0;
      rspq.push_back('{name: nm, on_irq: 1'b0, exp: e});
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      read_n     = 1'b1;
   endtask

   task automatic probe_irq(input logic e, input string nm);
      prbq.push_back('{name: nm, on_irq: 1'b1, exp: {15'd0, e}});
   endtask

   task automatic probe_rd(input logic [15:0] e, input string nm);
      prbq.push_back('{name: nm, on_irq: 1'b0, exp: e});
   endtask

   initial begin
      reset      = 1'b1;
      address    = 3'd0;
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      writedata  = 16'h0000;
      irq_in     = 8'h00;
      repeat (3) tick();
      reset = 1'b0;
      probe_irq(1'b0, "rst_cpu_irq");
      probe_rd(16'h0000, "rst_readdata");
      bus_rd(A_ENABLE,  16'h0000, "rst_enable");
      bus_rd(A_MODE,    16'h0000, "rst_mode");
      bus_rd(A_INSERV,  16'h0000, "rst_inservice");
      bus_rd(A_PENDING, 16'h0000, "rst_pending");

      // Level source 0: two-cycle latency, ack, EOI re-raise.
      bus_wr(A_ENABLE, 16'h0001);
      irq_in = 8'h01;
      probe_irq(1'b0, "lvl_n0");
      tick();
      probe_irq(1'b0, "lvl_n1");
      tick();
      probe_irq(1'b1, "lvl_n2");
      bus_rd(A_PENDING, 16'h0001, "lvl_pending");
      bus_rd(A_VECTOR,  16'h8000, "lvl_vector");
      probe_irq(1'b0, "lvl_irq_after_ack");
      bus_rd(A_INSERV,  16'h8000, "lvl_inservice");
      bus_rd(A_VECTOR,  16'h0000, "lvl_vector_active");
      bus_wr(A_INSERV,  16'h0000);
      probe_irq(1'b1, "lvl_irq_after_eoi");
      bus_rd(A_RAW,     16'h0001, "lvl_raw");
      irq_in = 8'h00;
      tick();
      tick();
      probe_irq(1'b0, "lvl_irq_released");
      bus_wr(A_ENABLE, 16'h0000);

      // Priority between edge sources 2 and 5.
      bus_wr(A_MODE,   16'h00FF);
      bus_wr(A_ENABLE, 16'h00FF);
      irq_in = 8'h24;
      tick();
      irq_in = 8'h00;
      tick();
      probe_irq(1'b1, "pri_irq");
      bus_rd(A_PENDING, 16'h0024, "pri_pending");
      bus_rd(A_VECTOR,  16'h8002, "pri_vector_2");
      bus_rd(A_PENDING, 16'h0020, "pri_pending_after_2");
      bus_wr(A_INSERV,  16'h0000);
      bus_rd(A_VECTOR,  16'h8005, "pri_vector_5");
      bus_rd(A_PENDING, 16'h0000, "pri_pending_empty");
      bus_wr(A_INSERV,  16'h0000);
      probe_irq(1'b0, "pri_irq_idle");

      // New edge on source 3 in the same cycle as its acknowledge.
      irq_in = 8'h08;
      tick();
      irq_in = 8'h00;
      tick();
      irq_in = 8'h08;
      bus_rd(A_VECTOR,  16'h8003, "col_vector");
      irq_in = 8'h00;
      bus_rd(A_PENDING, 16'h0008, "col_pending_kept");
      bus_rd(A_INSERV,  16'h8003, "col_inservice");
      bus_wr(A_INSERV,  16'h0000);
      bus_wr(A_PENDING, 16'h0008);
      bus_rd(A_PENDING, 16'h0000, "col_w1c");

      // W1C, level bit immunity, MODE clear, changes during ACTIVE.
      irq_in = 8'h14;
      tick();
      irq_in = 8'h00;
      tick();
      bus_rd(A_PENDING, 16'h0014, "w1c_pending");
      bus_wr(A_PENDING, 16'h0004);
      bus_rd(A_PENDING, 16'h0010, "w1c_after");
      bus_wr(A_MODE,    16'h00FE);
      irq_in = 8'h01;
      tick();
      bus_rd(A_PENDING, 16'h0011, "w1c_level_seen");
      bus_wr(A_PENDING, 16'h0001);
      bus_rd(A_PENDING, 16'h0011, "w1c_level_immune");
      bus_rd(A_VECTOR,  16'h8000, "w1c_vector_0");
      bus_rd(A_VECTOR,  16'h0000, "w1c_vector_active");
      bus_wr(A_MODE,    16'h00EE);
      bus_rd(A_PENDING, 16'h0001, "mode_clear_edge4");
      bus_wr(A_ENABLE,  16'h0000);
      bus_rd(A_INSERV,  16'h8000, "active_isr_kept");
      probe_irq(1'b0, "active_irq_low");
      bus_wr(A_INSERV,  16'h0000);

      // Simultaneous read and write, unused addresses.
      bus_wr(A_ENABLE, 16'h0001);
      bus_rw(A_VECTOR, 16'h0000, 16'h0000, "rw_vector_suppressed");
      bus_rd(A_INSERV, 16'h0000, "rw_no_ack");
      bus_wr(3'd6,     16'hFFFF);
      bus_rd(3'd6,     16'h0000, "addr6_zero");
      bus_rd(A_ENABLE, 16'h0001, "addr6_write_ignored");
      probe_irq(1'b1, "rw_irq_still_high");

      // Reset in the middle of ACTIVE, overriding a concurrent read.
      bus_rd(A_VECTOR, 16'h8000, "rst_mid_vector");
      reset = 1'b1;
      bus_rd(A_ENABLE, 16'h0000, "rst_mid_readdata");
      reset = 1'b0;
      probe_irq(1'b0, "rst_mid_irq");
      bus_rd(A_INSERV, 16'h0000, "rst_mid_inservice");
      bus_rd(A_ENABLE, 16'h0000, "rst_mid_enable");
      bus_rd(A_MODE,   16'h0000, "rst_mid_mode");
      bus_wr(A_ENABLE, 16'h0001);
      probe_irq(1'b0, "rst_reenable_n0");
      tick();
      probe_irq(1'b1, "rst_reenable_n1");

      repeat (3) tick();
      for (int i = 0; i < 10 && (rspq.size() > 0 || prbq.size() > 0); i++) tick();
      if (rspq.size() > 0 || prbq.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d responses and %0d probes outstanding, expected 0",
                  rspq.size(), prbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nes_irq_ctrl.md
NES_IRQ_CTRL -- requirements
Module: nes_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (fixed 8 for this revision; bits [15:8] of source registers read 0).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port address  input  3  Avalon-MM slave word address.
REQ-005 SHALL have port chipselect  input  1  slave select.
REQ-006 SHALL have port read_n  input  1  active-low read strobe, qualified by chipselect.
REQ-007 SHALL have port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-008 SHALL have port writedata  input  16  write data.
REQ-009 SHALL have port irq_in  input  8  interrupt requests from peripherals (bit 0 = timer irq), clk domain, active-high.
REQ-010 SHALL have port readdata  output  16  registered read data.
REQ-011 SHALL have port cpu_irq  output  1  registered interrupt request to CPU.

Function
REQ-012 SHALL implement the register map: 0 PENDING (R; W1C), 1 ENABLE (R/W), 2 MODE (R/W; 1=rising-edge, 0=level), 3 VECTOR (R; read = acknowledge), 4 INSERVICE (R; any write = EOI), 5 RAW (R, irq_in_d); addresses 6-7 read 0, writes ignored.
REQ-013 SHALL register irq_in once into irq_in_d every cycle; all detection uses irq_in_d.
REQ-014 SHALL, for edge sources, set edge_pend[i] on cycle after irq_in[i]=1 with irq_in_d[i]=0; for level sources, PENDING[i] = irq_in_d[i] (not latched).
REQ-015 SHALL clear edge_pend[i] on PENDING write with writedata[i]=1 for edge sources only; set beats clear in the same cycle.
REQ-016 SHALL clear edge_pend[i] whenever MODE write changes bit i to 0.
REQ-017 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE on VECTOR read with valid request; ACTIVE->IDLE on INSERVICE write; INSERVICE write in IDLE ignored.
REQ-018 SHALL define request = PENDING & ENABLE; winner = lowest set index (bit 0 highest priority).
REQ-019 SHALL register cpu_irq <= (state==IDLE) && |request each cycle; latency irq_in rise -> cpu_irq high = 2 cycles (edge or level).
REQ-020 SHALL, on VECTOR read in IDLE with |request, return {1'b1,12'b0,winner[2:0]}, load INSERVICE index=winner, clear edge_pend[winner] if edge source (new edge same cycle keeps it set), enter ACTIVE; cpu_irq low the following cycle.
REQ-021 SHALL, on VECTOR read in ACTIVE or with no request, return 16'h0000 with no state change.
REQ-022 SHALL return INSERVICE as {active,12'b0,index[2:0]}.
REQ-023 SHALL register readdata one cycle after the read strobe (read latency 1); readdata holds otherwise.
REQ-024 SHALL, if read and write asserted together, perform the write only, suppress read side effects, and load readdata 0.
REQ-025 SHALL not affect the in-service source when ENABLE/MODE change during ACTIVE.

Reset
REQ-026 SHALL, with reset=1 at a clock edge, clear irq_in_d, edge_pend, ENABLE, MODE, INSERVICE, readdata and cpu_irq to 0 and force IDLE, overriding any concurrent bus access.
REQ-027 SHALL, on reset mid-ACTIVE, drop cpu_irq and lose all pending/in-service state; a level source still high re-requests 2 cycles after reset deasserts if re-enabled.

Verification
REQ-028 Level: ENABLE=0x01, irq_in[0] high at cycle N -> cpu_irq=1 at N+2; VECTOR read -> readdata 0x8000, cpu_irq=0 next cycle; INSERVICE write -> cpu_irq=1 again 1 cycle later while irq_in[0] high.
REQ-029 Priority: MODE=0xFF, ENABLE=0xFF, pulses on irq_in[5] and irq_in[2] -> VECTOR reads 0x8002; after EOI, VECTOR reads 0x8005; PENDING then 0x0000.
REQ-030 Edge collision: edge source 3 acknowledged in same cycle as a new rising edge on irq_in[3] -> PENDING[3] stays 1 after ack.
REQ-031 W1C: edge_pend=0x14, write PENDING 0x04 -> reads 0x10; write to level bit has no effect; VECTOR read in ACTIVE -> 0x0000.
REQ-032 Reset mid-ACTIVE: assert reset one cycle -> cpu_irq=0, INSERVICE 0x0000, ENABLE 0x0000, readdata 0x0000.
